mem_port_arbiter: RTL and testbench

Shares one single-port synchronous memory between the core's instruction-fetch port and data port (unified-memory build).
- Grants at most one access per cycle.
- Data has priority; a starvation counter guarantees fetch progress.
- A response-tag delay line routes read data back to the requester that issued the read.
- Sits between the core's imem/dmem interfaces and the shared RAM.

---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_resp_pipe.sv | 39 +++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory-port arbiter: requester IDs and
// the response tag that travels alongside each in-flight read.
package arb_pkg;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } arb_src_e;

  typedef struct packed {
    logic     valid;
    arb_src_e src;
  } arb_tag_t;

  localparam int ARB_MAX_RD_LATENCY = 4;

  localparam arb_tag_t ARB_TAG_IDLE = '{valid: 1'b0, src: SRC_IF};

endpackage

// File: rtl/arb_resp_pipe.sv
// Response-tag delay line: one tag enters per cycle and emerges DEPTH cycles
// later, so read data can be steered back to whoever issued the read.
module arb_resp_pipe
  import arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_src,
  output logic o_valid,
  output logic o_src,
  output logic o_busy
);

  arb_tag_t r_stage [DEPTH];
  logic     w_anyValid;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= ARB_TAG_IDLE;
    end else begin
      r_stage[0] <= '{valid: i_valid, src: arb_src_e'(i_src)};
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  // Any valid tag, including the one at the output stage, means a read is still owed.
  always_comb begin
    w_anyValid = 1'b0;
    for (int i = 0; i < DEPTH; i++) w_anyValid = w_anyValid | r_stage[i].valid;
  end

  assign o_valid = r_stage[DEPTH-1].valid;
  assign o_src   = r_stage[DEPTH-1].src;
  assign o_busy  = w_anyValid;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data;
// data wins ties unless fetch has been starved for STARVE_LIMIT grants.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int         BE_W  = DATA_W / 8;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starveCnt;
  logic       w_ifGnt;
  logic       w_dGnt;
  logic       w_rdAccept;
  logic       w_tagValid;
  logic       w_tagSrc;
  logic       w_busy;

  // Reset blocks every grant so nothing reaches the RAM while rst is high.
  always_comb begin
    w_ifGnt = 1'b0;
    w_dGnt  = 1'b0;
    if (!rst) begin
      if (if_req && (!d_req || r_starveCnt == LIMIT)) w_ifGnt = 1'b1;
      else if (d_req)                                 w_dGnt  = 1'b1;
    end
  end

  assign if_gnt = w_ifGnt;
  assign d_gnt  = w_dGnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starveCnt <= 4'd0;
    end else if (w_ifGnt || !if_req) begin
      r_starveCnt <= 4'd0;
    end else if (w_dGnt && r_starveCnt != LIMIT) begin
      r_starveCnt <= r_starveCnt + 4'd1;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (w_ifGnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      mem_be   = {BE_W{1'b1}};
    end else if (w_dGnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_we ? d_be : {BE_W{1'b1}};
    end
  end

  // A fetch grant is always a read; the source bit is simply "data was granted".
  assign w_rdAccept = w_ifGnt | (w_dGnt & ~d_we);

  arb_resp_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_respPipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_rdAccept),
    .i_src   (w_dGnt),
    .o_valid (w_tagValid),
    .o_src   (w_tagSrc),
    .o_busy  (w_busy)
  );

  assign if_rvalid = !rst && w_tagValid && (w_tagSrc == SRC_IF);
  assign d_rvalid  = !rst && w_tagValid && (w_tagSrc == SRC_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;
  assign busy      = !rst && w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (read latency 1 and 3) driven by the same directed vectors, each
// with its own RAM model; read responses are checked through per-DUT queues.
module tb_mem_port_arbiter;

  typedef struct {
    logic        src;
    logic [31:0] data;
    int          g;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [3:0]  dBe;

  logic        ifGnt    [2];
  logic        ifRvalid [2];
  logic [31:0] ifRdata  [2];
  logic        dGnt     [2];
  logic        dRvalid  [2];
  logic [31:0] dRdata   [2];
  logic        memEn    [2];
  logic        memWe    [2];
  logic [31:0] memAddr  [2];
  logic [31:0] memWdata [2];
  logic [3:0]  memBe    [2];
  logic [31:0] memRdata [2];
  logic        busy     [2];

  logic [31:0] ram    [2][16];
  logic [31:0] rdPipe [2][4];

  exp_t qA [$];
  exp_t qB [$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(LAT0), .STARVE_LIMIT(4)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_gnt(ifGnt[0]), .if_rvalid(ifRvalid[0]), .if_rdata(ifRdata[0]),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_be(dBe),
    .d_gnt(dGnt[0]), .d_rvalid(dRvalid[0]), .d_rdata(dRdata[0]),
    .mem_en(memEn[0]), .mem_we(memWe[0]), .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]),
    .mem_be(memBe[0]), .mem_rdata(memRdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(LAT1), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_gnt(ifGnt[1]), .if_rvalid(ifRvalid[1]), .if_rdata(ifRdata[1]),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_be(dBe),
    .d_gnt(dGnt[1]), .d_rvalid(dRvalid[1]), .d_rdata(dRdata[1]),
    .mem_en(memEn[1]), .mem_we(memWe[1]), .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]),
    .mem_be(memBe[1]), .mem_rdata(memRdata[1]), .busy(busy[1])
  );

  function automatic logic [31:0] mergeBe(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // RAM model per DUT: word 4 (0x10) holds 0xDEADBEEF, word i otherwise 0x11110000+i.
  // Idle cycles return a junk pattern so that rdata gating is visible.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (preload) begin
        for (int i = 0; i < 16; i++) ram[k][i] <= (i == 4) ? 32'hDEADBEEF : 32'h11110000 + 32'(i);
      end else if (memEn[k] && memWe[k]) begin
        ram[k][memAddr[k][5:2]] <= mergeBe(ram[k][memAddr[k][5:2]], memWdata[k], memBe[k]);
      end
      rdPipe[k][0] <= (memEn[k] && !memWe[k]) ? ram[k][memAddr[k][5:2]] : 32'hBAD0BAD0;
      for (int s = 1; s < 4; s++) rdPipe[k][s] <= rdPipe[k][s-1];
    end
  end

  assign memRdata[0] = rdPipe[0][LAT0-1];
  assign memRdata[1] = rdPipe[1][LAT1-1];

  task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d cyc=%0d: got %h, want %h", name, k, cyc, act, exp);
    end
  endtask

  // Pops the oldest outstanding read once its latency has elapsed and checks
  // rvalid routing, data, rdata gating and busy against the queue contents.
  task automatic monitorDut(input int k);
    exp_t q [$];
    exp_t e;
    int   lat;
    logic expIfV, expDV, expBusy;
    if (k == 0) begin q = qA; lat = LAT0; end
    else        begin q = qB; lat = LAT1; end
    expBusy = 1'b0;
    foreach (q[i]) if (q[i].g + 1 <= cyc && cyc <= q[i].g + lat) expBusy = 1'b1;
    checkOutput("busy", k, 32'(busy[k]), 32'(expBusy));
    expIfV = 1'b0;
    expDV  = 1'b0;
    if (q.size() > 0 && q[0].g + lat == cyc) begin
      if (q[0].src) expDV = 1'b1;
      else          expIfV = 1'b1;
    end
    checkOutput("if_rvalid", k, 32'(ifRvalid[k]), 32'(expIfV));
    checkOutput("d_rvalid", k, 32'(dRvalid[k]), 32'(expDV));
    if (expIfV || expDV) begin
      e = q.pop_front();
      if (e.src) checkOutput("d_rdata", k, dRdata[k], e.data);
      else       checkOutput("if_rdata", k, ifRdata[k], e.data);
    end
    if (!expIfV) checkOutput("if_rdata_idle", k, ifRdata[k], 32'h0);
    if (!expDV)  checkOutput("d_rdata_idle", k, dRdata[k], 32'h0);
    if (k == 0) qA = q;
    else        qB = q;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitorDut(0);
      monitorDut(1);
    end
  end

  // One bus cycle: drive the request, check grants and the RAM drive against
  // the hand-computed outcome, and queue the read data that must come back.
  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                               input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                               input logic eIf, input logic eD, input logic [31:0] eData);
    logic [31:0] expAddr, expWd;
    logic [3:0]  expBe;
    exp_t        e;
    @(posedge clk);
    #2;
    rst = 1'b0;
    ifReq = ir; ifAddr = ia;
    dReq = dr; dWe = dwe; dAddr = da; dWdata = dwd; dBe = dbe;
    #1;
    expAddr = eIf ? ia : (eD ? da : 32'h0);
    expWd   = eD ? dwd : 32'h0;
    expBe   = eIf ? 4'hF : (eD ? (dwe ? dbe : 4'hF) : 4'h0);
    for (int k = 0; k < 2; k++) begin
      checkOutput("if_gnt", k, 32'(ifGnt[k]), 32'(eIf));
      checkOutput("d_gnt", k, 32'(dGnt[k]), 32'(eD));
      checkOutput("mem_en", k, 32'(memEn[k]), 32'(eIf | eD));
      checkOutput("mem_we", k, 32'(memWe[k]), 32'(eD & dwe));
      checkOutput("mem_addr", k, memAddr[k], expAddr);
      checkOutput("mem_wdata", k, memWdata[k], expWd);
      checkOutput("mem_be", k, 32'(memBe[k]), 32'(expBe));
    end
    if (eIf || (eD && !dwe)) begin
      e.src  = eD;
      e.data = eData;
      e.g    = cyc;
      qA.push_back(e);
      qB.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Holds reset for one cycle with both requesters asking; in-flight reads are dropped.
  task automatic applyReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    ifReq = 1'b1; ifAddr = 32'h10;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h14; dWdata = 32'h0; dBe = 4'h0;
    qA.delete();
    qB.delete();
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_if_gnt", k, 32'(ifGnt[k]), 32'h0);
      checkOutput("rst_d_gnt", k, 32'(dGnt[k]), 32'h0);
      checkOutput("rst_mem_en", k, 32'(memEn[k]), 32'h0);
      checkOutput("rst_mem_we", k, 32'(memWe[k]), 32'h0);
      checkOutput("rst_mem_addr", k, memAddr[k], 32'h0);
      checkOutput("rst_mem_wdata", k, memWdata[k], 32'h0);
      checkOutput("rst_mem_be", k, 32'(memBe[k]), 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    ifReq = 1'b0; ifAddr = 32'h0;
    dReq = 1'b0; dWe = 1'b0; dAddr = 32'h0; dWdata = 32'h0; dBe = 4'h0;
    repeat (2) @(posedge clk);
    #2 preload = 1'b0;
    applyReset();

    // Fetch read, data read next cycle, then a byte-masked write.
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
    applyStimulus(0, 0, 1, 0, 32'h14, 0, 0, 0, 1, 32'h11110005);
    applyStimulus(0, 0, 1, 1, 32'h20, 32'h12345678, 4'b0011, 0, 1, 0);
    idle(4);
    applyStimulus(0, 0, 1, 0, 32'h20, 0, 0, 0, 1, 32'h11115678);
    idle(1);

    // Both requesters held: data writes win four times, then fetch is forced.
    for (int i = 0; i < 11; i++)
      applyStimulus(1, 32'h04, 1, 1, 32'h30, 32'hA5A5A5A5, 4'hF, (i % 5 == 4), (i % 5 != 4), 32'h11110001);
    idle(4);
    applyStimulus(0, 0, 1, 0, 32'h30, 0, 0, 0, 1, 32'hA5A5A5A5);

    // Back-to-back reads from both ports return in issue order.
    applyStimulus(1, 32'h08, 0, 0, 0, 0, 0, 1, 0, 32'h11110002);
    applyStimulus(1, 32'h0C, 0, 0, 0, 0, 0, 1, 0, 32'h11110003);
    applyStimulus(0, 0, 1, 0, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF);
    applyStimulus(1, 32'h18, 0, 0, 0, 0, 0, 1, 0, 32'h11110006);
    idle(4);

    // Reads in flight with a part-filled starvation count, then reset.
    applyStimulus(1, 32'h04, 1, 0, 32'h14, 0, 0, 0, 1, 32'h11110005);
    applyStimulus(1, 32'h04, 1, 0, 32'h14, 0, 0, 0, 1, 32'h11110005);
    applyReset();
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 32'h04, 1, 1, 32'h3C, 32'h0, 4'hF, (i == 4), (i != 4), 32'h11110001);
    idle(5);

    checkOutput("leftover_reads", 0, 32'(qA.size()), 32'h0);
    checkOutput("leftover_reads", 1, 32'(qB.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
